// File: rtl/multimode_ff_bank.sv
// Bank of WIDTH flip-flops, each behaving as JK, SR, D or T according to the shared mode input.
// Define MMFF_SR_ERR_EN to build the sticky SR-illegal (j&k in SR mode) detector driving err.
module multimode_ff_bank #(
  parameter int unsigned       WIDTH   = 8,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] chg,
  output logic             err
);

  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_SR = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_chg;
  logic [WIDTH-1:0] w_q_nxt;

  always_comb begin
    w_q_nxt = r_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      case (mode)
        MODE_JK: begin
          case ({j[i], k[i]})
            2'b01:   w_q_nxt[i] = 1'b0;
            2'b10:   w_q_nxt[i] = 1'b1;
            2'b11:   w_q_nxt[i] = ~r_q[i];
            default: w_q_nxt[i] = r_q[i];
          endcase
        end
        MODE_SR: begin
          // SR 11 is illegal and simply holds the bit
          case ({j[i], k[i]})
            2'b01:   w_q_nxt[i] = 1'b0;
            2'b10:   w_q_nxt[i] = 1'b1;
            default: w_q_nxt[i] = r_q[i];
          endcase
        end
        MODE_D:  w_q_nxt[i] = j[i];
        MODE_T:  w_q_nxt[i] = r_q[i] ^ j[i];
        default: w_q_nxt[i] = r_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= RST_VAL;
      r_chg <= '0;
    end else if (en) begin
      r_q   <= w_q_nxt;
      r_chg <= w_q_nxt ^ r_q;
    end else begin
      r_chg <= '0;
    end
  end

`ifdef MMFF_SR_ERR_EN
  logic r_err;
  logic w_sr_ill;

  assign w_sr_ill = en && (mode == MODE_SR) && (|(j & k));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_sr_ill) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign q   = r_q;
  assign qb  = ~r_q;
  assign chg = r_chg;

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed bench for multimode_ff_bank (WIDTH=8, RST_VAL=8'hA5) using an expected-value queue.
// Honours MMFF_SR_ERR_EN when predicting err.
module tb_multimode_ff_bank;

  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] mode;
  logic [7:0] j, k, q, qb, chg;
  logic       err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic [7:0] chg;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_q   = 8'h00;
  logic       m_err = 1'b0;

  multimode_ff_bank #(
    .WIDTH  (8),
    .RST_VAL(RV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .mode(mode),
    .j   (j),
    .k   (k),
    .q   (q),
    .qb  (qb),
    .chg (chg),
    .err (err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_next(input logic [1:0] md, input logic [7:0] jj,
                                            input logic [7:0] kk, input logic [7:0] qq);
    logic [7:0] n;
    for (int i = 0; i < 8; i++) begin
      if (md == 2'b10)      n[i] = jj[i];
      else if (md == 2'b11) n[i] = qq[i] ^ jj[i];
      else if (jj[i] && !kk[i]) n[i] = 1'b1;
      else if (!jj[i] && kk[i]) n[i] = 1'b0;
      else if (jj[i] && kk[i] && md == 2'b00) n[i] = ~qq[i];
      else n[i] = qq[i];
    end
    return n;
  endfunction

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, push the model prediction, then pop and compare after the edge.
  task automatic step(input string tag, input logic r, input logic e, input logic [1:0] md,
                      input logic [7:0] jj, input logic [7:0] kk);
    exp_t x;
    logic [7:0] n;
    rst = r; en = e; mode = md; j = jj; k = kk;
    if (r) begin
      x.chg = 8'h00; m_q = RV; m_err = 1'b0;
    end else if (e) begin
      n = model_next(md, jj, kk, m_q);
      x.chg = n ^ m_q;
      m_q = n;
`ifdef MMFF_SR_ERR_EN
      if (md == 2'b01 && (jj & kk) != 8'h00) m_err = 1'b1;
`endif
    end else begin
      x.chg = 8'h00;
    end
    x.tag = tag; x.q = m_q; x.err = m_err;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk8({x.tag, ".q"}, q, x.q);
    chk8({x.tag, ".qb"}, qb, ~x.q);
    chk8({x.tag, ".chg"}, chg, x.chg);
    chk8({x.tag, ".err"}, {7'b0, err}, {7'b0, x.err});
  endtask

  logic exp_sr_err;

  initial begin
`ifdef MMFF_SR_ERR_EN
    exp_sr_err = 1'b1;
`else
    exp_sr_err = 1'b0;
`endif
    rst = 1'b0; en = 1'b0; mode = 2'b00; j = 8'h00; k = 8'h00;
    @(negedge clk);

    step("reset", 1'b1, 1'b1, 2'b11, 8'hFF, 8'h00);
    chk8("reset.q_const", q, 8'hA5);
    chk8("reset.qb_const", qb, 8'h5A);
    chk8("reset.chg_const", chg, 8'h00);
    chk8("reset.err_const", {7'b0, err}, 8'h00);

    step("d_clear", 1'b0, 1'b1, 2'b10, 8'h00, 8'hFF);
    chk8("d_clear.chg_const", chg, 8'hA5);
    step("jk_setclr", 1'b0, 1'b1, 2'b00, 8'hF0, 8'h0F);
    chk8("jk_setclr.q_const", q, 8'hF0);
    chk8("jk_setclr.chg_const", chg, 8'hF0);
    step("jk_toggle", 1'b0, 1'b1, 2'b00, 8'hFF, 8'hFF);
    chk8("jk_toggle.q_const", q, 8'h0F);
    chk8("jk_toggle.chg_const", chg, 8'hFF);
    step("jk_hold", 1'b0, 1'b1, 2'b00, 8'h00, 8'h00);

    step("d_3c", 1'b0, 1'b1, 2'b10, 8'h3C, 8'h00);
    step("sr_ill", 1'b0, 1'b1, 2'b01, 8'h81, 8'h01);
    chk8("sr_ill.q_const", q, 8'hBC);
    chk8("sr_ill.err_const", {7'b0, err}, {7'b0, exp_sr_err});
    for (int i = 0; i < 3; i++) step("sr_idle", 1'b0, 1'b0, 2'b01, 8'hFF, 8'hFF);
    chk8("sr_sticky.err_const", {7'b0, err}, {7'b0, exp_sr_err});
    step("sr_clr", 1'b0, 1'b1, 2'b01, 8'h00, 8'h0C);
    chk8("sr_clr.q_const", q, 8'hB0);

    step("d_zero", 1'b0, 1'b1, 2'b10, 8'h00, 8'hAA);
    step("d_55", 1'b0, 1'b1, 2'b10, 8'h55, 8'hFF);
    chk8("d_55.q_const", q, 8'h55);
    step("t_0f", 1'b0, 1'b1, 2'b11, 8'h0F, 8'hFF);
    chk8("t_0f.q_const", q, 8'h5A);
    chk8("t_0f.chg_const", chg, 8'h0F);

    for (int i = 0; i < 4; i++) begin
      step("hold", 1'b0, 1'b0, 2'($urandom_range(3)), 8'($urandom), 8'($urandom));
      chk8("hold.q_const", q, 8'h5A);
      chk8("hold.chg_const", chg, 8'h00);
    end

    for (int i = 0; i < 3; i++) step("t_ff", 1'b0, 1'b1, 2'b11, 8'hFF, 8'h00);
    step("mid_rst", 1'b1, 1'b1, 2'b11, 8'hFF, 8'h00);
    chk8("mid_rst.q_const", q, RV);
    chk8("mid_rst.chg_const", chg, 8'h00);
    chk8("mid_rst.err_const", {7'b0, err}, 8'h00);
    step("post_rst_t", 1'b0, 1'b1, 2'b11, 8'hFF, 8'h00);
    chk8("post_rst_t.q_const", q, ~RV);
    chk8("post_rst_t.chg_const", chg, 8'hFF);

    // Random mixed traffic against the model, reset sprinkled in.
    for (int i = 0; i < 40; i++) begin
      step("rand", ($urandom_range(15) == 0), 1'($urandom), 2'($urandom_range(3)),
           8'($urandom), 8'($urandom));
    end

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
